// File: rtl/ram_n_if.sv
// Bus bundle for ram_n: write data, shared address, load/clear controls, read data and ready.
// The master drives the requests and the slave (the RAM) returns data and status.
interface ram_n_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              ready;

    modport master (
        output in, address, load, clear,
        input  out, ready
    );

    modport slave (
        input  in, address, load, clear,
        output out, ready
    );
endinterface

// File: rtl/ram_n.sv
// Parametrised RAM with synchronous write, combinational read and a hardware clear sweep.
// The sweep runs after reset and on request; reads return zero until the sweep completes.
module ram_n #(
    parameter int              WIDTH       = 16,
    parameter int              DEPTH       = 8,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic    clock,
    input  logic    reset_n,
    ram_n_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // A clear request always wins: it restarts the sweep from word 0 in either state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        case (state_q)
            ST_CLEAR: begin
                if (bus.clear) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.address;
        mem_wdata = bus.in;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = CLEAR_VALUE;
            end
            ST_IDLE: begin
                mem_we = bus.load && !bus.clear;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        bus.ready = ready_q;
        bus.out   = ready_q ? mem[bus.address] : '0;
    end

    // Storage has no reset; its contents are defined by the sweep or by loads.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_ram_n.sv
// Scoreboard bench for ram_n: an 8x16 instance and a 32x8 (CLEAR_VALUE=8'h3C) instance side by side.
// A sweep-countdown reference model predicts ready/out; a negedge monitor compares.
module tb_ram_n;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  rst_v;
    int          addr_v  [2];
    logic [15:0] in_v    [2];
    logic        load_v  [2];
    logic        clear_v [2];

    ram_n_if #(.WIDTH(16), .DEPTH(8))  bus8 ();
    ram_n_if #(.WIDTH(8),  .DEPTH(32)) bus32 ();

    assign bus8.in       = in_v[0];
    assign bus8.address  = 3'(addr_v[0]);
    assign bus8.load     = load_v[0];
    assign bus8.clear    = clear_v[0];
    assign bus32.in      = in_v[1][7:0];
    assign bus32.address = 5'(addr_v[1]);
    assign bus32.load    = load_v[1];
    assign bus32.clear   = clear_v[1];

    ram_n #(.WIDTH(16), .DEPTH(8), .CLEAR_VALUE(16'h0000)) dut8 (
        .clock   (clock),
        .reset_n (rst_v[0]),
        .bus     (bus8)
    );

    ram_n #(.WIDTH(8), .DEPTH(32), .CLEAR_VALUE(8'h3C)) dut32 (
        .clock   (clock),
        .reset_n (rst_v[1]),
        .bus     (bus32)
    );

    typedef struct {
        bit          rdy;
        logic [15:0] data;
        int          addr;
    } exp_t;

    exp_t q_exp [2][$];

    // Reference model: a countdown of edges left in the sweep, and the visible word array.
    int          m_depth [2];
    logic [15:0] m_clr   [2];
    logic [15:0] m_mask  [2];
    logic [15:0] m_mem   [2][32];
    int          m_left  [2];
    bit          m_rdy   [2];

    int checks   = 0;
    int failures = 0;

    function automatic void modelReset(input int d);
        m_left[d] = m_depth[d];
        m_rdy[d]  = 1'b0;
    endfunction

    function automatic void modelEdge(input int d);
        if (!rst_v[d]) begin
            modelReset(d);
        end else if (!m_rdy[d]) begin
            if (clear_v[d]) begin
                m_left[d] = m_depth[d];
            end else begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_rdy[d] = 1'b1;
                    for (int i = 0; i < m_depth[d]; i++) m_mem[d][i] = m_clr[d];
                end
            end
        end else if (clear_v[d]) begin
            modelReset(d);
        end else if (load_v[d]) begin
            m_mem[d][addr_v[d]] = in_v[d] & m_mask[d];
        end
    endfunction

    function automatic void pushExpect(input int d);
        exp_t e;
        e.rdy  = m_rdy[d];
        e.data = m_rdy[d] ? m_mem[d][addr_v[d]] : 16'h0000;
        e.addr = addr_v[d];
        q_exp[d].push_back(e);
    endfunction

    task automatic setInputs(input int d, input int a, input logic [15:0] din,
                             input logic ld, input logic cl);
        addr_v[d]  = a % m_depth[d];
        in_v[d]    = din;
        load_v[d]  = ld;
        clear_v[d] = cl;
    endtask

    // Called 2 time units after a rising edge: record expectations, then take the next edge.
    task automatic applyStimulus();
        pushExpect(0);
        pushExpect(1);
        @(posedge clock);
        modelEdge(0);
        modelEdge(1);
        #2;
    endtask

    // Half-cycle asynchronous reset pulse in the middle of a cycle.
    task automatic resetPulse(input int d);
        rst_v[d] = 1'b0;
        modelReset(d);
        pushExpect(0);
        pushExpect(1);
        #5;
        rst_v[d] = 1'b1;
        @(posedge clock);
        modelEdge(0);
        modelEdge(1);
        #2;
    endtask

    task automatic checkOutput(input string name, input exp_t e,
                               input logic rdy, input logic [15:0] dat);
        checks++;
        if (rdy !== e.rdy) begin
            failures++;
            $display("[TB] FAIL %s_ready addr=%0d actual=%b required=%b at %0t",
                     name, e.addr, rdy, e.rdy, $time);
        end
        checks++;
        if (dat !== e.data) begin
            failures++;
            $display("[TB] FAIL %s_out addr=%0d actual=%h required=%h at %0t",
                     name, e.addr, dat, e.data, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q_exp[0].size() > 0) begin
                e = q_exp[0].pop_front();
                checkOutput("ram8", e, bus8.ready, bus8.out);
            end
            if (q_exp[1].size() > 0) begin
                e = q_exp[1].pop_front();
                checkOutput("ram32", e, bus32.ready, {8'h00, bus32.out});
            end
        end
    end

    initial begin
        m_depth[0] = 8;  m_clr[0] = 16'h0000; m_mask[0] = 16'hFFFF;
        m_depth[1] = 32; m_clr[1] = 16'h003C; m_mask[1] = 16'h00FF;
        rst_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            setInputs(d, 0, 16'h0000, 1'b0, 1'b0);
            modelReset(d);
        end
        @(posedge clock);
        #2;
        applyStimulus();
        applyStimulus();
        rst_v = 2'b11;

        // Initial sweep; loads to address 1 on edges 2-5 of the small RAM must be ignored.
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 4) setInputs(0, 1, 16'hFFFF, 1'b1, 1'b0);
            else                  setInputs(0, $urandom_range(0, 7), 16'h0000, 1'b0, 1'b0);
            setInputs(1, $urandom_range(0, 31), 16'($urandom), 1'b1, 1'b0);
            applyStimulus();
        end
        setInputs(1, 0, 16'h0000, 1'b0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            setInputs(0, a, 16'h0000, 1'b0, 1'b0);
            applyStimulus();
        end

        setInputs(0, 3, 16'hA5A5, 1'b1, 1'b0); applyStimulus();
        setInputs(0, 3, 16'h0000, 1'b0, 1'b0); applyStimulus();
        setInputs(0, 7, 16'h1234, 1'b1, 1'b0); applyStimulus();
        setInputs(0, 7, 16'h0000, 1'b0, 1'b0); applyStimulus();
        setInputs(0, 2, 16'h0000, 1'b0, 1'b0); applyStimulus();

        // Clear and load on the same edge: clear wins, then a sweep with ignored loads.
        setInputs(0, 3, 16'h5555, 1'b1, 1'b1); applyStimulus();
        for (int i = 0; i < 8; i++) begin
            setInputs(0, 3, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            applyStimulus();
        end
        setInputs(0, 3, 16'h0000, 1'b0, 1'b0); applyStimulus();

        // Clear mid-sweep restarts a full sweep.
        setInputs(0, 0, 16'h0000, 1'b0, 1'b1); applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setInputs(0, i, 16'h0000, 1'b0, 1'b0); applyStimulus();
        end
        setInputs(0, 5, 16'h0000, 1'b0, 1'b1); applyStimulus();
        for (int i = 0; i < 9; i++) begin
            setInputs(0, $urandom_range(0, 7), 16'h0000, 1'b0, 1'b0); applyStimulus();
        end

        // Reset pulse after sweep edge 4, then a reset pulse while ready.
        setInputs(0, 0, 16'h0000, 1'b0, 1'b1); applyStimulus();
        for (int i = 0; i < 4; i++) begin
            setInputs(0, i, 16'h0000, 1'b0, 1'b0); applyStimulus();
        end
        resetPulse(0);
        for (int i = 0; i < 9; i++) begin
            setInputs(0, $urandom_range(0, 7), 16'h0000, 1'b0, 1'b0); applyStimulus();
        end
        setInputs(0, 4, 16'h0000, 1'b0, 1'b0);
        resetPulse(0);
        for (int i = 0; i < 9; i++) begin
            setInputs(0, i, 16'h0000, 1'b0, 1'b0); applyStimulus();
        end

        // Wide-depth variant: every word reads the clear value, then a write to the top word.
        for (int a = 0; a < 32; a++) begin
            setInputs(1, a, 16'h0000, 1'b0, 1'b0); applyStimulus();
        end
        setInputs(1, 31, 16'h0081, 1'b1, 1'b0); applyStimulus();
        setInputs(1, 31, 16'h0000, 1'b0, 1'b0); applyStimulus();

        // Random traffic on both instances with occasional clear requests.
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 2; d++) begin
                setInputs(d, $urandom_range(0, 31), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
            end
            applyStimulus();
        end

        checks++;
        if (q_exp[0].size() != 0 || q_exp[1].size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d/%0d required=0/0",
                     q_exp[0].size(), q_exp[1].size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_n.md
# ram_n

Parametrised random-access memory: the generalised successor to the fixed 8×16 RAM building block. It provides WIDTH-bit words across DEPTH locations, with a synchronous write and an asynchronous (combinational) read. A hardware clear sequencer initialises every word to CLEAR_VALUE after reset and on request, and a `ready` flag marks when the array may be used. The block serves as the storage primitive for the larger RAM tiers and the register-file work that follows.

## Interface

- WIDTH, 16, word width in bits; ≥1
- DEPTH, 8, number of words; power of two, ≥2
- CLEAR_VALUE, 0 (WIDTH bits), value written to every word by the clear sweep
- ADDR_W, $clog2(DEPTH), derived; not overridden by instantiators
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  write data
- address  input  ADDR_W  read and write address (shared)
- load  input  1  write enable; honoured only when `ready`=1 and `clear`=0
- clear  input  1  request a full re-initialisation sweep
- out  output  WIDTH  read data
- ready  output  1  array initialised and accepting loads

## Operation

- Storage: DEPTH×WIDTH array. No per-word reset; contents are defined only by the sweep or by writes.
- FSM states: CLEAR and IDLE. An internal pointer `ptr` is ADDR_W bits wide.
- Reset (reset_n=0, asynchronous): state ← CLEAR, ptr ← 0, ready ← 0. The state holds while reset_n is low.
- CLEAR: each rising edge writes CLEAR_VALUE to mem[ptr].
  - If ptr≠DEPTH−1, then ptr ← ptr+1.
  - If ptr=DEPTH−1, then state ← IDLE, ready ← 1, ptr ← 0. The pointer wraps to 0 and never exceeds DEPTH−1.
- IDLE: on a rising edge with load=1 and clear=0, mem[address] ← in. The other words are unchanged.
- IDLE with clear=1: state ← CLEAR, ptr ← 0, ready ← 0 on that edge. A load asserted on the same edge is dropped (clear has priority).
- CLEAR with clear=1: the sweep restarts. ptr ← 0 and state stays CLEAR, so a fresh DEPTH-cycle sweep begins.
- Loads while ready=0 are ignored. They must not disturb the sweep.
- Read port:
  - When ready=1, out = mem[address], combinationally.
  - When ready=0, out = 0 (all bits). The port never exposes uninitialised or half-swept contents.
- Width rules: `in` and `out` are exactly WIDTH bits. The address is taken modulo DEPTH by construction (ADDR_W bits), with no out-of-range case.

## Timing

- Output values during and immediately after reset: ready=0, out=0.
- Sweep length: exactly DEPTH rising edges, counted from the first edge with reset_n=1 (or from the edge that samples clear=1 in IDLE). ready goes high after edge DEPTH.
  - For DEPTH=8, ready is first 1 after the 8th edge.
- Write latency: data written on edge N is visible on `out` (same address) combinationally after edge N. There is no read-during-write bypass: before the edge, out shows the old word.
- Read latency: zero cycles. `out` follows `address` combinationally while ready=1.
- Reset mid-sweep or mid-operation: all state returns to CLEAR/ptr 0/ready 0 immediately, without waiting for a clock edge. The sweep restarts after release.
- reset_n deassertion is expected synchronous to `clock` from upstream. No internal synchroniser is provided.

## Test plan

- Reset, then release with DEPTH=8, WIDTH=16, CLEAR_VALUE=16'h0000 -> ready=0 and out=0 for edges 1–7; ready=1 after edge 8; reading addresses 0–7 returns 16'h0000.
- Ready=1, write in=16'hA5A5 to address 3 and 16'h1234 to address 7 -> after each edge, out at that address equals the written value; address 2 still reads 16'h0000.
- load=1 during the sweep (edges 2–5, address 1, in=16'hFFFF) -> ignored; after ready=1, address 1 reads CLEAR_VALUE.
- Ready=1, clear=1 and load=1 on the same edge (address 3, in=16'h5555) -> ready=0 next, out=0, 8-cycle sweep; afterwards address 3 reads 16'h0000, not 16'h5555.
- reset_n pulsed low for half a cycle at sweep edge 4 -> ready stays 0 and ptr is 0; a full 8-edge sweep follows release.
- Parameter variant DEPTH=32, WIDTH=8, CLEAR_VALUE=8'h3C -> ready after 32 edges; every address reads 8'h3C; a write to address 31 with in=8'h81 reads back 8'h81.
